streebog_ctrl: RTL and testbench

Message-level sequencer for the GOST R 34.11-2012 (Streebog) hash core. It accepts 512-bit message blocks and maintains the chaining value h, the length counter N and the checksum Sigma. It applies final-block padding and drives the shared g_function compression unit through the block stage and the two finalization calls g_0(h,N) and g_0(h,Sigma). It sits between the host-side block interface and the single g_function instance.

---
 rtl/streebog_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_streebog_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/streebog_ctrl.sv
// Message-level sequencer for the Streebog hash: padding, h/N/Sigma upkeep, g_function issue.
// Optional STREEBOG_256_EN adds mode_256_i for the 256-bit digest variant.
module streebog_ctrl #(
   parameter int unsigned DATA_WIDTH = 512
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic [DATA_WIDTH-1:0] msg_data_i,
   input  logic                  msg_valid_i,
   input  logic                  msg_last_i,
   input  logic [9:0]            msg_bits_i,
   output logic                  msg_ready_o,
`ifdef STREEBOG_256_EN
   input  logic                  mode_256_i,
`endif
   output logic [DATA_WIDTH-1:0] g_n_o,
   output logic [DATA_WIDTH-1:0] g_m_o,
   output logic [DATA_WIDTH-1:0] g_h_o,
   output logic                  g_valid_o,
   input  logic [DATA_WIDTH-1:0] g_hash_i,
   input  logic                  g_hash_valid_i,
   output logic [DATA_WIDTH-1:0] digest_o,
   output logic                  digest_valid_o,
   output logic                  busy_o
);

   localparam int unsigned LenW = 10;

   typedef enum logic [2:0] {
      StIdle, StIssueB, StWaitB, StIssueN, StWaitN, StIssueS, StWaitS, StDone
   } state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] h_q, h_d, n_q, n_d, sigma_q, sigma_d, m_q, m_d;
   logic [DATA_WIDTH-1:0] gh_q, gh_d, gn_q, gn_d, gm_q, gm_d, digest_q, digest_d;
   logic [LenW-1:0]       len_q, len_d;
   logic                  final_q, final_d, pend_q, pend_d, first_q, first_d, mode_q, mode_d;

   logic                  mode_sel, full_blk;
   logic [DATA_WIDTH-1:0] iv, h_start, pad_blk, in_blk, n_sum, one_blk;

`ifdef STREEBOG_256_EN
   assign mode_sel = first_q ? mode_256_i : mode_q;
`else
   assign mode_sel = 1'b0;
`endif

   // IV is only needed when the first block of a message enters the core.
   assign iv       = mode_sel ? {(DATA_WIDTH/8){8'h01}} : '0;
   assign h_start  = first_q ? iv : h_q;
   assign one_blk  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
   assign full_blk = !msg_last_i || (msg_bits_i >= 10'd512);
   assign pad_blk  = (msg_data_i & ~({DATA_WIDTH{1'b1}} << msg_bits_i)) | (one_blk << msg_bits_i);
   assign in_blk   = full_blk ? msg_data_i : pad_blk;
   assign n_sum    = n_q + {{(DATA_WIDTH-LenW){1'b0}}, len_q};

   always_comb begin
      state_d  = state_q;
      h_d      = h_q;
      n_d      = n_q;
      sigma_d  = sigma_q;
      m_d      = m_q;
      gh_d     = gh_q;
      gn_d     = gn_q;
      gm_d     = gm_q;
      digest_d = digest_q;
      len_d    = len_q;
      final_d  = final_q;
      pend_d   = pend_q;
      first_d  = first_q;
      mode_d   = mode_q;
      unique case (state_q)
         StIdle: begin
            if (msg_valid_i) begin
               m_d     = in_blk;
               len_d   = full_blk ? 10'd512 : msg_bits_i;
               final_d = !full_blk;
               pend_d  = full_blk && msg_last_i;
               mode_d  = mode_sel;
               first_d = 1'b0;
               gh_d    = h_start;
               gn_d    = n_q;
               gm_d    = in_blk;
               state_d = StIssueB;
            end
         end
         StIssueB: state_d = StWaitB;
         StWaitB: begin
            if (g_hash_valid_i) begin
               h_d     = g_hash_i;
               n_d     = n_sum;
               sigma_d = sigma_q + m_q;
               gh_d    = g_hash_i;
               if (final_q) begin
                  gn_d    = '0;
                  gm_d    = n_sum;
                  state_d = StIssueN;
               end else if (pend_q) begin
                  // Exactly-512-bit final block: follow with the bare padding block.
                  m_d     = one_blk;
                  len_d   = '0;
                  final_d = 1'b1;
                  pend_d  = 1'b0;
                  gn_d    = n_sum;
                  gm_d    = one_blk;
                  state_d = StIssueB;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StIssueN: state_d = StWaitN;
         StWaitN: begin
            if (g_hash_valid_i) begin
               h_d     = g_hash_i;
               gh_d    = g_hash_i;
               gn_d    = '0;
               gm_d    = sigma_q;
               state_d = StIssueS;
            end
         end
         StIssueS: state_d = StWaitS;
         StWaitS: begin
            if (g_hash_valid_i) begin
               h_d      = g_hash_i;
               digest_d = mode_q ? {g_hash_i[DATA_WIDTH-1:DATA_WIDTH/2], {(DATA_WIDTH/2){1'b0}}}
                                 : g_hash_i;
               state_d  = StDone;
            end
         end
         StDone: begin
            h_d     = '0;
            n_d     = '0;
            sigma_d = '0;
            first_d = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q  <= StIdle;
         h_q      <= '0;
         n_q      <= '0;
         sigma_q  <= '0;
         m_q      <= '0;
         gh_q     <= '0;
         gn_q     <= '0;
         gm_q     <= '0;
         digest_q <= '0;
         len_q    <= '0;
         final_q  <= 1'b0;
         pend_q   <= 1'b0;
         first_q  <= 1'b1;
         mode_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         h_q      <= h_d;
         n_q      <= n_d;
         sigma_q  <= sigma_d;
         m_q      <= m_d;
         gh_q     <= gh_d;
         gn_q     <= gn_d;
         gm_q     <= gm_d;
         digest_q <= digest_d;
         len_q    <= len_d;
         final_q  <= final_d;
         pend_q   <= pend_d;
         first_q  <= first_d;
         mode_q   <= mode_d;
      end
   end

   assign msg_ready_o    = (state_q == StIdle);
   assign busy_o         = (state_q != StIdle);
   assign g_valid_o      = (state_q == StIssueB) || (state_q == StIssueN) || (state_q == StIssueS);
   assign digest_valid_o = (state_q == StDone);
   assign g_h_o          = gh_q;
   assign g_n_o          = gn_q;
   assign g_m_o          = gm_q;
   assign digest_o       = digest_q;

endmodule

// File: tb/tb_streebog_ctrl.sv
// Bench for streebog_ctrl: a stub g_function ((h^m)+n, random latency) and a message-level model.
// Define STREEBOG_256_EN to also exercise the 256-bit digest mode.
module tb_streebog_ctrl;

   logic         clk_i = 1'b0;
   logic         rstn_i;
   logic [511:0] msg_data;
   logic         msg_valid, msg_last;
   logic [9:0]   msg_bits;
   logic         msg_ready_o;
`ifdef STREEBOG_256_EN
   logic         mode_256;
`endif
   logic [511:0] g_n_o, g_m_o, g_h_o, g_hash_i, digest_o;
   logic         g_valid_o, g_hash_valid_i, digest_valid_o, busy_o;

   logic         stub_hv, spur_hv;
   logic [511:0] stub_res, spur_data;
   logic [511:0] cap_h[$], cap_n[$], cap_m[$];
   int           overlap_cnt = 0;
   int           n_checks = 0;
   int           n_fail = 0;
   logic [511:0] empty_dig;

   assign g_hash_valid_i = stub_hv | spur_hv;
   assign g_hash_i       = stub_hv ? stub_res : spur_data;

   always #5 clk_i = ~clk_i;

   streebog_ctrl #(.DATA_WIDTH(512)) dut (
      .clk_i          (clk_i),
      .rstn_i         (rstn_i),
      .msg_data_i     (msg_data),
      .msg_valid_i    (msg_valid),
      .msg_last_i     (msg_last),
      .msg_bits_i     (msg_bits),
      .msg_ready_o    (msg_ready_o),
`ifdef STREEBOG_256_EN
      .mode_256_i     (mode_256),
`endif
      .g_n_o          (g_n_o),
      .g_m_o          (g_m_o),
      .g_h_o          (g_h_o),
      .g_valid_o      (g_valid_o),
      .g_hash_i       (g_hash_i),
      .g_hash_valid_i (g_hash_valid_i),
      .digest_o       (digest_o),
      .digest_valid_o (digest_valid_o),
      .busy_o         (busy_o)
   );

   function automatic logic [511:0] gref(input logic [511:0] h, input logic [511:0] n,
                                         input logic [511:0] m);
      return (h ^ m) + n;
   endfunction

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [511:0] capm(input int i);
      return (i < cap_m.size()) ? cap_m[i] : 'x;
   endfunction

   function automatic logic [511:0] capn(input int i);
      return (i < cap_n.size()) ? cap_n[i] : 'x;
   endfunction

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   // g_function stand-in: one result per g_valid_o pulse after a random delay.
   initial begin
      int lat;
      stub_hv  = 1'b0;
      stub_res = '0;
      @(negedge clk_i);
      forever begin
         if (rstn_i === 1'b1 && g_valid_o === 1'b1) begin
            cap_h.push_back(g_h_o);
            cap_n.push_back(g_n_o);
            cap_m.push_back(g_m_o);
            stub_res = gref(g_h_o, g_n_o, g_m_o);
            lat = $urandom_range(1, 6);
            repeat (lat) begin
               @(negedge clk_i);
               if (g_valid_o === 1'b1) overlap_cnt++;
            end
            stub_hv = 1'b1;
            @(negedge clk_i);
            stub_hv = 1'b0;
         end else begin
            @(negedge clk_i);
         end
      end
   end

   task automatic send_block(input logic [511:0] d, input logic last, input logic [9:0] bits,
                             input bit inject);
      int k = 0;
      while (msg_ready_o !== 1'b1 && k < 300) begin
         @(negedge clk_i);
         k++;
      end
      check1("ready_wait", k < 300, 1'b1);
      msg_data  = d;
      msg_last  = last;
      msg_bits  = bits;
      msg_valid = 1'b1;
      @(negedge clk_i);
      msg_valid = 1'b0;
      check1("issue_latency", g_valid_o, 1'b1);
      if (inject) begin
         msg_data  = rand512();
         msg_last  = 1'b1;
         msg_bits  = 10'd3;
         msg_valid = 1'b1;
         @(negedge clk_i);
         msg_valid = 1'b0;
      end
   endtask

   task automatic run_msg(input int nfull, input int bits, input bit ones, input bit inject,
                          input bit spur, input bit mode, output logic [511:0] dig);
      logic [511:0] blk[$], pm[$], eh[$], en[$], em[$];
      int           pl[$];
      logic [511:0] fd, h, n, s, m, held;
      int           b, k;
      for (int i = 0; i < nfull; i++) blk.push_back(ones ? {512{1'b1}} : rand512());
      fd = ones ? {512{1'b1}} : rand512();
      b  = (bits > 512) ? 512 : bits;
      foreach (blk[i]) begin
         pm.push_back(blk[i]);
         pl.push_back(512);
      end
      if (b == 512) begin
         pm.push_back(fd);
         pl.push_back(512);
         pm.push_back(512'd1);
         pl.push_back(0);
      end else begin
         m = '0;
         for (int j = 0; j < b; j++) m[j] = fd[j];
         m[b] = 1'b1;
         pm.push_back(m);
         pl.push_back(b);
      end
      h = mode ? {64{8'h01}} : '0;
      n = '0;
      s = '0;
      foreach (pm[i]) begin
         eh.push_back(h);
         en.push_back(n);
         em.push_back(pm[i]);
         h = gref(h, n, pm[i]);
         n = n + 512'(pl[i]);
         s = s + pm[i];
      end
      eh.push_back(h); en.push_back('0); em.push_back(n); h = gref(h, '0, n);
      eh.push_back(h); en.push_back('0); em.push_back(s); h = gref(h, '0, s);
      dig = mode ? {h[511:256], 256'd0} : h;

      cap_h.delete(); cap_n.delete(); cap_m.delete();
      if (spur) begin
         spur_data = rand512();
         spur_hv   = 1'b1;
         @(negedge clk_i);
         spur_hv   = 1'b0;
      end
`ifdef STREEBOG_256_EN
      mode_256 = mode;
`endif
      foreach (blk[i]) send_block(blk[i], 1'b0, 10'($urandom_range(0, 511)), inject);
      send_block(fd, 1'b1, 10'(bits), 1'b0);
      k = 0;
      while (digest_valid_o !== 1'b1 && k < 500) begin
         @(negedge clk_i);
         k++;
      end
      check1("digest_wait", k < 500, 1'b1);
      check("digest", digest_o, dig);
      check1("ready_in_done", msg_ready_o, 1'b0);
      held = digest_o;
      @(negedge clk_i);
      check1("digest_pulse", digest_valid_o, 1'b0);
      check1("ready_after", msg_ready_o, 1'b1);
      check("digest_held", digest_o, held);
      check("call_count", 512'(cap_m.size()), 512'(em.size()));
      foreach (em[i]) begin
         if (i < cap_m.size()) begin
            check($sformatf("call%0d_h", i), cap_h[i], eh[i]);
            check($sformatf("call%0d_n", i), cap_n[i], en[i]);
            check($sformatf("call%0d_m", i), cap_m[i], em[i]);
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check1({tag, "_ready"}, msg_ready_o, 1'b1);
      check1({tag, "_gvalid"}, g_valid_o, 1'b0);
      check({tag, "_gn"}, g_n_o, '0);
      check({tag, "_gm"}, g_m_o, '0);
      check({tag, "_gh"}, g_h_o, '0);
      check({tag, "_digest"}, digest_o, '0);
      check1({tag, "_dvalid"}, digest_valid_o, 1'b0);
      check1({tag, "_busy"}, busy_o, 1'b0);
   endtask

   initial begin
      logic [511:0] dig;
      int           k;
      rstn_i    = 1'b0;
      msg_data  = '0;
      msg_valid = 1'b0;
      msg_last  = 1'b0;
      msg_bits  = '0;
      spur_hv   = 1'b0;
      spur_data = '0;
`ifdef STREEBOG_256_EN
      mode_256  = 1'b0;
`endif
      repeat (3) @(negedge clk_i);
      check_reset_outputs("rst");
      rstn_i = 1'b1;
      @(negedge clk_i);
      check_reset_outputs("post_rst");

      // Exactly 512-bit final block: four calls, explicit pad block.
      run_msg(0, 512, 1'b1, 1'b0, 1'b0, 1'b0, dig);
      check("full_ncalls", 512'(cap_m.size()), 512'd4);
      check("full_c1_m", capm(1), 512'd1);
      check("full_c1_n", capn(1), 512'd512);
      check("full_c2_m", capm(2), 512'd512);

      // Empty message.
      run_msg(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, empty_dig);
      check("empty_c0_m", capm(0), 512'd1);
      check("empty_c0_n", capn(0), 512'd0);
      check("empty_c2_m", capm(2), 512'd1);

      // Two full blocks then 8 bits, with spurious result strobe and busy-time valid.
      run_msg(2, 8, 1'b0, 1'b1, 1'b1, 1'b0, dig);
      check("three_ncalls", 512'(cap_m.size()), 512'd5);
      check("three_c0_n", capn(0), 512'd0);
      check("three_c1_n", capn(1), 512'd512);
      check("three_c2_n", capn(2), 512'd1024);

      for (int i = 0; i < 5; i++)
         run_msg($urandom_range(0, 2), $urandom_range(0, 700), 1'b0, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0, dig);

`ifdef STREEBOG_256_EN
      run_msg(1, 100, 1'b0, 1'b0, 1'b0, 1'b1, dig);
      check("m256_low", {256'd0, digest_o[255:0]}, '0);
      run_msg(0, 40, 1'b0, 1'b0, 1'b0, 1'b0, dig);
      mode_256 = 1'b0;
`endif

      // Abort in WAIT_N, then an empty message must reproduce the earlier digest.
      cap_h.delete(); cap_n.delete(); cap_m.delete();
      send_block(rand512(), 1'b1, 10'd0, 1'b0);
      k = 0;
      while (cap_m.size() < 2 && k < 300) begin
         @(negedge clk_i);
         k++;
      end
      check1("reach_wait_n", k < 300, 1'b1);
      @(negedge clk_i);
      rstn_i = 1'b0;
      #1;
      check_reset_outputs("abort");
      repeat (2) @(negedge clk_i);
      rstn_i = 1'b1;
      repeat (10) @(negedge clk_i);
      check1("abort_no_digest", digest_valid_o, 1'b0);
      run_msg(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, dig);
      check("abort_digest", digest_o, empty_dig);

      check("no_overlap", 512'(overlap_cnt), 512'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
